stepper_phase_decoder: RTL and testbench
========================================

Name: stepper_phase_decoder

Overview:
- Reads the 4-bit half-step coil pattern driven onto motorpin by the elevator motor controllers.
- Reconstructs step events, direction, absolute step position and current floor from that pattern.
- Lives beside the elevator controller as a position monitor and self-check: the reading end of the motorpin interface.
- Flags skipped steps, illegal coil patterns and stalls so higher-level logic can detect drive faults.

Parameters:
- STEPS_PER_FLOOR, 11719, half-steps between adjacent floors (1030 deg at 4096 steps/rev).
- NUM_FLOORS, 3, number of served floors.
- POS_W, 24, width of signed step position.
- FLOOR_W, 2, width of floor index.
- GLITCH_CYCLES, 4, clocks a synced pattern must be stable before acceptance (min 1).
- STALL_CYCLES, 1000000, clocks without an accepted step before moving drops.

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous active-high reset
- coil  in  4  motorpin pattern under observation (asynchronous to clk)
- clr_err  in  1  clears sticky error flags and err_count
- step_pulse  out  1  one-clock pulse per accepted step
- dir  out  1  direction of last accepted step; 0 = up (index +1), 1 = down (index -1)
- position  out  POS_W  signed two's-complement half-step count since reset
- floor  out  FLOOR_W  current floor index
- at_floor  out  1  high when position lies exactly on a floor boundary
- moving  out  1  step accepted within the last STALL_CYCLES clocks
- locked  out  1  a valid reference index is held
- err_skip  out  1  sticky; index jumped by 2..4 (mod 8)
- err_invalid  out  1  sticky; illegal coil pattern accepted
- err_count  out  8  saturating count of skip and invalid events

Behaviour:
- Reset, asynchronous: all outputs 0, except at_floor = 1. Internal state is UNLOCKED, sub-counter 0, last index 0.
- Input sync: 2-flop synchronizer on coil.
- Stability filter: a counter restarts on any change of the synced value. A pattern is accepted once, on the edge where it has been stable for GLITCH_CYCLES clocks.
- Total latency from the first clk edge sampling a new coil value to step_pulse high is GLITCH_CYCLES+3 edges.
- Decode table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- 0000 = de-energized: no event. State, index and position are held.
- Any other pattern is illegal: pulse an internal error, set err_invalid, go UNLOCKED.
- State UNLOCKED: the first accepted valid pattern loads the last index. Go LOCKED; no step is counted.
- State LOCKED: delta = (new - last) mod 8.
  - delta 0: nothing.
  - delta 1: up step.
  - delta 7: down step.
  - delta 2..6: set err_skip, load the new index, no position change, stay LOCKED.
- Step accepted: step_pulse = 1 for one clk; dir updated; position +/-1 in the same cycle as step_pulse; last index updated.
- Floor tracking uses a sub-counter 0..STEPS_PER_FLOOR-1:
  - Up at STEPS_PER_FLOOR-1: sub-counter goes to 0, floor +1.
  - Down at 0: sub-counter goes to STEPS_PER_FLOOR-1, floor -1.
  - floor wraps mod 2^FLOOR_W.
  - at_floor = (sub-counter == 0).
- position wraps in two's complement.
- moving: set by step_pulse. A stall counter reloads on each step; moving clears when the counter reaches STALL_CYCLES with no step.
- err_count: +1 per skip or invalid event, saturating at 255.
- clr_err clears err_skip, err_invalid, err_count. If an error event occurs in the same cycle as clr_err, the error wins: flag = 1, count = 1.
- Reset mid-filter or mid-motion: everything returns to reset values. The next pattern is a fresh reference (UNLOCKED).

Optional Feature:
- Macro: STEP_DECODER_LIMIT_EN.
- Defined:
  - Adds sticky output err_limit (1 bit, reset 0, cleared by clr_err, counted in err_count).
  - Set when an accepted step makes position < 0 or > (NUM_FLOORS-1)*STEPS_PER_FLOOR.
  - The step is still applied to position and floor.
- Undefined: no err_limit port; no range check.

Test Plan:
1. Reset, then coil = 1000 held: locked = 1 after 7 clk (GLITCH_CYCLES = 4), position 0, no step_pulse, at_floor = 1.
2. Sequence 1000 -> 1100 -> 0100, each held 10 clk: two step_pulses, each 7 edges after its change; dir = 0; position = 2. Reverse back to 1000: dir = 1, position = 0.
3. STEPS_PER_FLOOR = 8 override, 8 up steps: floor 0 -> 1 with at_floor = 1 on the 8th step. One down step: floor = 0, at_floor = 0, position = 7.
4. Jump 1000 -> 0100: err_skip = 1, err_count = 1, position unchanged. Then coil = 1010: err_invalid = 1, locked = 0, err_count = 2. Pulse clr_err: all flags and count 0.
5. Glitch: 1100 for 2 clk between two 1000 periods: no step, no error. Coil 0000 for 50 clk then 1100: one up step counted.
6. STALL_CYCLES = 20: one step, then none for 20 clk: moving falls on the 20th clk. With STEP_DECODER_LIMIT_EN, one down step from 0: err_limit = 1, position = -1.

Source files
------------

// File: rtl/stepper_phase_decoder_if.sv
// Signal bundle for the motorpin observer: pattern and error clear in, decoded motion and fault status out.
// Defining STEP_DECODER_LIMIT_EN adds the err_limit status signal.
interface stepper_phase_decoder_if #(
  parameter int POS_W   = 24,
  parameter int FLOOR_W = 2
);
  logic [3:0]         coil;
  logic               clr_err;
  logic               step_pulse;
  logic               dir;
  logic [POS_W-1:0]   position;
  logic [FLOOR_W-1:0] floor;
  logic               at_floor;
  logic               moving;
  logic               locked;
  logic               err_skip;
  logic               err_invalid;
  logic [7:0]         err_count;
`ifdef STEP_DECODER_LIMIT_EN
  logic               err_limit;

  modport master (
    output coil, clr_err,
    input  step_pulse, dir, position, floor, at_floor, moving, locked,
           err_skip, err_invalid, err_count, err_limit
  );
  modport slave (
    input  coil, clr_err,
    output step_pulse, dir, position, floor, at_floor, moving, locked,
           err_skip, err_invalid, err_count, err_limit
  );
`else
  modport master (
    output coil, clr_err,
    input  step_pulse, dir, position, floor, at_floor, moving, locked,
           err_skip, err_invalid, err_count
  );
  modport slave (
    input  coil, clr_err,
    output step_pulse, dir, position, floor, at_floor, moving, locked,
           err_skip, err_invalid, err_count
  );
`endif
endinterface

// File: rtl/stepper_phase_decoder.sv
// Half-step coil pattern decoder: reconstructs steps, direction, position and floor, and flags drive faults.
// Optional range check on position enabled by defining STEP_DECODER_LIMIT_EN.
module stepper_phase_decoder #(
  parameter int STEPS_PER_FLOOR = 11719,
  parameter int NUM_FLOORS      = 3,
  parameter int POS_W           = 24,
  parameter int FLOOR_W         = 2,
  parameter int GLITCH_CYCLES   = 4,
  parameter int STALL_CYCLES    = 1000000
) (
  input  logic                    clk,
  input  logic                    reset_p,
  stepper_phase_decoder_if.slave  bus
);

  localparam int SUB_W = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
  localparam int GC_W  = $clog2(GLITCH_CYCLES + 1);
  localparam int ST_W  = $clog2(STALL_CYCLES + 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(STEPS_PER_FLOOR - 1);

  if (GLITCH_CYCLES < 1 || NUM_FLOORS < 1) begin : g_bad_param
    $error("stepper_phase_decoder: GLITCH_CYCLES and NUM_FLOORS must be at least 1");
  end

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [3:0]          sync1, sync2, stab_val, acc_val;
  logic [GC_W-1:0]     stab_cnt;
  logic                acc;
  logic [2:0]          new_idx, last_idx, delta;
  logic                pat_valid, pat_zero;
  logic                step_up, step_dn, skip_ev, inv_ev, limit_ev, load_idx, err_ev;
  logic                step_pulse_q, dir_q, moving_q;
  logic signed [POS_W-1:0] pos_q, pos_nxt;
  logic [SUB_W-1:0]    sub_q;
  logic [FLOOR_W-1:0]  floor_q;
  logic [ST_W-1:0]     stall_q;
  logic                err_skip_q, err_invalid_q;
  logic [7:0]          err_count_q;

  // Sync, then accept a pattern exactly once, on the edge its stable run reaches GLITCH_CYCLES.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1    <= '0;
      sync2    <= '0;
      stab_val <= '0;
      stab_cnt <= '0;
      acc      <= 1'b0;
      acc_val  <= '0;
    end else begin
      sync1 <= bus.coil;
      sync2 <= sync1;
      acc   <= 1'b0;
      if (sync2 != stab_val) begin
        stab_val <= sync2;
        stab_cnt <= GC_W'(1);
        if (GLITCH_CYCLES == 1) begin
          acc     <= 1'b1;
          acc_val <= sync2;
        end
      end else if (stab_cnt < GC_W'(GLITCH_CYCLES)) begin
        stab_cnt <= stab_cnt + GC_W'(1);
        if (stab_cnt == GC_W'(GLITCH_CYCLES - 1)) begin
          acc     <= 1'b1;
          acc_val <= sync2;
        end
      end
    end
  end

  always_comb begin
    new_idx   = '0;
    pat_valid = 1'b1;
    pat_zero  = 1'b0;
    case (acc_val)
      4'b1000: new_idx = 3'd0;
      4'b1100: new_idx = 3'd1;
      4'b0100: new_idx = 3'd2;
      4'b0110: new_idx = 3'd3;
      4'b0010: new_idx = 3'd4;
      4'b0011: new_idx = 3'd5;
      4'b0001: new_idx = 3'd6;
      4'b1001: new_idx = 3'd7;
      4'b0000: begin
        pat_valid = 1'b0;
        pat_zero  = 1'b1;
      end
      default: pat_valid = 1'b0;
    endcase
  end

  assign delta = new_idx - last_idx;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state_q <= UNLOCKED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc && !pat_zero) state_d = pat_valid ? LOCKED : UNLOCKED;
  end

  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    skip_ev  = 1'b0;
    inv_ev   = 1'b0;
    load_idx = 1'b0;
    if (acc && !pat_zero) begin
      if (!pat_valid) begin
        inv_ev = 1'b1;
      end else begin
        load_idx = 1'b1;
        if (state_q == LOCKED) begin
          case (delta)
            3'd0:    ;
            3'd1:    step_up = 1'b1;
            3'd7:    step_dn = 1'b1;
            default: skip_ev = 1'b1;
          endcase
        end
      end
    end
  end

  assign pos_nxt = step_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

`ifdef STEP_DECODER_LIMIT_EN
  localparam logic signed [POS_W-1:0] MAX_POS = POS_W'((NUM_FLOORS - 1) * STEPS_PER_FLOOR);
  logic err_limit_q;

  assign limit_ev = (step_up || step_dn) && (pos_nxt[POS_W-1] || (pos_nxt > MAX_POS));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) err_limit_q <= 1'b0;
    else         err_limit_q <= limit_ev | (err_limit_q & ~bus.clr_err);
  end

  assign bus.err_limit = err_limit_q;
`else
  assign limit_ev = 1'b0;
`endif

  assign err_ev = skip_ev | inv_ev | limit_ev;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      step_pulse_q  <= 1'b0;
      dir_q         <= 1'b0;
      pos_q         <= '0;
      sub_q         <= '0;
      floor_q       <= '0;
      last_idx      <= '0;
      moving_q      <= 1'b0;
      stall_q       <= '0;
      err_skip_q    <= 1'b0;
      err_invalid_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      step_pulse_q <= step_up | step_dn;
      if (load_idx) last_idx <= new_idx;
      if (step_up || step_dn) begin
        dir_q    <= step_dn;
        pos_q    <= pos_nxt;
        moving_q <= 1'b1;
        stall_q  <= '0;
        if (step_up) begin
          if (sub_q == SUB_MAX) begin
            sub_q   <= '0;
            floor_q <= floor_q + FLOOR_W'(1);
          end else begin
            sub_q <= sub_q + SUB_W'(1);
          end
        end else if (sub_q == '0) begin
          sub_q   <= SUB_MAX;
          floor_q <= floor_q - FLOOR_W'(1);
        end else begin
          sub_q <= sub_q - SUB_W'(1);
        end
      end else if (moving_q) begin
        // moving drops on the edge the idle count reaches STALL_CYCLES
        if (stall_q == ST_W'(STALL_CYCLES - 1)) moving_q <= 1'b0;
        stall_q <= stall_q + ST_W'(1);
      end
      err_skip_q    <= skip_ev | (err_skip_q & ~bus.clr_err);
      err_invalid_q <= inv_ev | (err_invalid_q & ~bus.clr_err);
      if (err_ev) begin
        if (bus.clr_err)               err_count_q <= 8'd1;
        else if (err_count_q != '1)    err_count_q <= err_count_q + 8'd1;
      end else if (bus.clr_err) begin
        err_count_q <= '0;
      end
    end
  end

  assign bus.step_pulse  = step_pulse_q;
  assign bus.dir         = dir_q;
  assign bus.position    = pos_q;
  assign bus.floor       = floor_q;
  assign bus.at_floor    = (sub_q == '0);
  assign bus.moving      = moving_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_skip    = err_skip_q;
  assign bus.err_invalid = err_invalid_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed plan plus random pattern walk against a rule-level model.
// Honours STEP_DECODER_LIMIT_EN for the err_limit checks.
module tb_stepper_phase_decoder;
  localparam int SPF = 8, NF = 3, POS_W = 24, FLOOR_W = 2, GC = 4, STALL = 20;

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  stepper_phase_decoder_if #(.POS_W(POS_W), .FLOOR_W(FLOOR_W)) bus ();

  stepper_phase_decoder #(
    .STEPS_PER_FLOOR(SPF), .NUM_FLOORS(NF), .POS_W(POS_W), .FLOOR_W(FLOOR_W),
    .GLITCH_CYCLES(GC), .STALL_CYCLES(STALL)
  ) dut (.clk(clk), .reset_p(reset_p), .bus(bus));

  int checks = 0, errors = 0;
  int pulse_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus.step_pulse === 1'b1) pulse_cnt++;
  end

  logic [3:0] pat_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

  int m_locked, m_last, m_pos, m_sub, m_floor, m_dir, m_skip, m_inv, m_lim, m_cnt, m_steps = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_locked = 0; m_last = 0; m_pos = 0; m_sub = 0; m_floor = 0; m_dir = 0;
    m_skip = 0; m_inv = 0; m_lim = 0; m_cnt = 0;
  endtask

  task automatic m_clr();
    m_skip = 0; m_inv = 0; m_lim = 0; m_cnt = 0;
  endtask

  task automatic m_err();
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic m_step(input int s);
    m_pos += s;
    m_dir = (s < 0);
    m_steps++;
    m_sub += s;
    if (m_sub == SPF) begin m_sub = 0; m_floor = (m_floor + 1) % 4; end
    else if (m_sub < 0) begin m_sub = SPF - 1; m_floor = (m_floor + 3) % 4; end
`ifdef STEP_DECODER_LIMIT_EN
    if (m_pos < 0 || m_pos > (NF - 1) * SPF) begin m_lim = 1; m_err(); end
`endif
  endtask

  task automatic m_accept(input logic [3:0] p);
    int i, d;
    i = idx_of(p);
    if (p == 4'b0000) return;
    if (i < 0) begin m_inv = 1; m_err(); m_locked = 0; return; end
    if (m_locked == 0) begin m_locked = 1; m_last = i; return; end
    d = (i - m_last + 8) % 8;
    m_last = i;
    if (d == 1)      m_step(1);
    else if (d == 7) m_step(-1);
    else if (d != 0) begin m_skip = 1; m_err(); end
  endtask

  task automatic check_all();
    check("dir", 32'(bus.dir), 32'(m_dir));
    check("position", 32'(bus.position), 32'(m_pos & 32'hFFFFFF));
    check("floor", 32'(bus.floor), 32'(m_floor));
    check("at_floor", 32'(bus.at_floor), 32'(m_sub == 0));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("err_skip", 32'(bus.err_skip), 32'(m_skip));
    check("err_invalid", 32'(bus.err_invalid), 32'(m_inv));
    check("err_count", 32'(bus.err_count), 32'(m_cnt));
    check("pulses", 32'(pulse_cnt), 32'(m_steps));
`ifdef STEP_DECODER_LIMIT_EN
    check("err_limit", 32'(bus.err_limit), 32'(m_lim));
`endif
  endtask

  task automatic check_reset();
    check("rst_step_pulse", 32'(bus.step_pulse), 0);
    check("rst_moving", 32'(bus.moving), 0);
    check("rst_at_floor", 32'(bus.at_floor), 1);
    check_all();
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    bus.coil = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [3:0] p, input int n);
    hold(p, n);
    m_accept(p);
    check_all();
  endtask

  task automatic step_next(input int s);
    apply(pat_tab[(m_last + s + 8) % 8], 10);
  endtask

  task automatic timed_step(input logic [3:0] p);
    int first;
    first = 0;
    bus.coil = p;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.step_pulse === 1'b1 && first == 0) first = i;
    end
    m_accept(p);
    check("step_latency", 32'(first), GC + 3);
    check_all();
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_clr();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    m_reset();
    check_reset();
  endtask

  initial begin
    int found, kind, n;
    logic [3:0] p, prev;
    reset_p = 1'b1;
    bus.coil = 4'b0000;
    bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    m_reset();
    check_reset();

    // Plan 1: first pattern becomes the reference after GC+3 edges
    bus.coil = 4'b1000;
    repeat (6) @(negedge clk);
    check("locked_early", 32'(bus.locked), 0);
    @(negedge clk);
    check("locked_edge7", 32'(bus.locked), 1);
    repeat (3) @(negedge clk);
    m_accept(4'b1000);
    check_all();

    // Plan 2: up, up, then back down
    timed_step(4'b1100);
    timed_step(4'b0100);
    check("pos_two_up", 32'(bus.position), 2);
    check("dir_up", 32'(bus.dir), 0);
    timed_step(4'b1100);
    timed_step(4'b1000);
    check("pos_back", 32'(bus.position), 0);
    check("dir_down", 32'(bus.dir), 1);

    // Plan 3: floor crossing both ways
    for (int i = 0; i < 8; i++) step_next(1);
    check("floor_up", 32'(bus.floor), 1);
    check("at_floor_up", 32'(bus.at_floor), 1);
    step_next(-1);
    check("floor_down", 32'(bus.floor), 0);
    check("at_floor_down", 32'(bus.at_floor), 0);
    check("pos_seven", 32'(bus.position), 7);

    // Plan 4: skip, invalid, clear
    apply(pat_tab[(m_last + 2) % 8], 10);
    check("skip_flag", 32'(bus.err_skip), 1);
    check("skip_count", 32'(bus.err_count), 1);
    check("skip_pos", 32'(bus.position), 7);
    apply(4'b1010, 10);
    check("inv_flag", 32'(bus.err_invalid), 1);
    check("inv_unlock", 32'(bus.locked), 0);
    check("inv_count", 32'(bus.err_count), 2);
    pulse_clr();
    check("clr_count", 32'(bus.err_count), 0);

    // Plan 5: glitch rejected, de-energized gap holds state
    apply(4'b1000, 10);
    hold(4'b1100, 2);
    apply(4'b1000, 10);
    apply(4'b0000, 50);
    apply(4'b1100, 10);

    // Error event coinciding with clr_err: the event wins
    apply(pat_tab[(m_last + 3) % 8], 10);
    bus.coil = 4'b1010;
    repeat (6) @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_clr();
    m_accept(4'b1010);
    repeat (2) @(negedge clk);
    check("collide_count", 32'(bus.err_count), 1);
    check("collide_inv", 32'(bus.err_invalid), 1);
    check_all();

    // Plan 6: stall detection
    apply(4'b1000, 10);
    bus.coil = pat_tab[(m_last + 1) % 8];
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      @(negedge clk);
      if (bus.step_pulse === 1'b1) found = 1;
    end
    check("stall_step_seen", 32'(found), 1);
    m_accept(bus.coil);
    repeat (STALL - 1) @(negedge clk);
    check("moving_before_stall", 32'(bus.moving), 1);
    @(negedge clk);
    check("moving_after_stall", 32'(bus.moving), 0);
    check_all();

    // Reset mid-filter, then a fresh reference and a step below zero
    bus.coil = pat_tab[(m_last + 1) % 8];
    repeat (3) @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    m_accept(bus.coil);
    check_all();
    step_next(-1);
    check("pos_neg_wrap", 32'(bus.position), 32'h00FFFFFF);
    check("floor_neg_wrap", 32'(bus.floor), 3);
`ifdef STEP_DECODER_LIMIT_EN
    check("limit_flag", 32'(bus.err_limit), 1);
`endif
    pulse_clr();

    // err_count saturation
    for (int i = 0; i < 260; i++) apply((i % 2) ? 4'b0101 : 4'b1010, 8);
    check("count_saturated", 32'(bus.err_count), 255);
    pulse_clr();

    // Random walk
    apply(4'b1000, 10);
    for (int it = 0; it < 200; it++) begin
      kind = int'($urandom_range(0, 11));
      n = int'($urandom_range(8, 14));
      prev = bus.coil;
      if (kind <= 3)       apply(pat_tab[(m_last + 1) % 8], n);
      else if (kind <= 6)  apply(pat_tab[(m_last + 7) % 8], n);
      else if (kind == 7)  apply(pat_tab[(m_last + int'($urandom_range(2, 6))) % 8], n);
      else if (kind == 8)  apply(4'b0000, n);
      else if (kind == 9) begin
        do p = 4'($urandom); while (p == 4'b0000 || idx_of(p) >= 0);
        apply(p, n);
      end else if (kind == 10) begin
        hold(4'($urandom), int'($urandom_range(1, 2)));
        apply(prev, n);
      end else begin
        pulse_clr();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
